// File: rtl/alu_md_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_md_if
// Purpose  : Request/result bundle between a requester and the alu_md engine.
// Revision : 1.0
// ============================================================================
interface alu_md_if #(
    parameter int XLEN = 32
) ();
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [4:0]      func;
    logic [XLEN-1:0] ALUout;
    logic            valid_o;
    logic            ready_i;

    modport master (
        output valid_i, SrcA, SrcB, func, ready_i,
        input  ready_o, ALUout, valid_o
    );

    modport slave (
        input  valid_i, SrcA, SrcB, func, ready_i,
        output ready_o, ALUout, valid_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
// Module   : alu_md
// Purpose  : Single-cycle base ALU plus iterative shift-add multiply and
//            restoring divide, with a valid/ready request and result handshake.
// Revision : 1.0
// ============================================================================
module alu_md #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst,
    alu_md_if.slave bus
);
    localparam int              c_shw  = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_ones = '1;
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_ready;
    logic   w_valid;
    logic   w_last;

    logic [XLEN-1:0]  r_alu_out;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_opb;
    logic [2:0]       r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [c_shw-1:0] r_cnt;

    logic [c_shw-1:0] w_shamt;
    logic [XLEN-1:0]  w_base_res;
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_special;
    logic [XLEN-1:0]  w_special_res;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_iter_res;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready  = 1'b1;
                w_accept = bus.valid_i;
                if (bus.valid_i) begin
                    w_state_nxt = (!bus.func[4] || w_special) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_last = (r_cnt == c_shw'(XLEN - 1));

    // ------------------------------------------------------------------
    // Single-cycle base operations
    // ------------------------------------------------------------------
    assign w_shamt = bus.SrcB[c_shw-1:0];

    always_comb begin
        w_base_res = '0;
        case (bus.func[3:0])
            4'b0000: w_base_res = bus.SrcA + bus.SrcB;
            4'b1000: w_base_res = bus.SrcA - bus.SrcB;
            4'b0001: w_base_res = bus.SrcA << w_shamt;
            4'b0010: w_base_res = {{(XLEN-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            4'b0011: w_base_res = {{(XLEN-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            4'b0100: w_base_res = bus.SrcA ^ bus.SrcB;
            4'b0101: w_base_res = bus.SrcA >> w_shamt;
            4'b1101: w_base_res = $unsigned($signed(bus.SrcA) >>> w_shamt);
            4'b0110: w_base_res = bus.SrcA | bus.SrcB;
            4'b0111: w_base_res = bus.SrcA & bus.SrcB;
            4'b1110: w_base_res = bus.SrcB;
            default: w_base_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Mul/div operand preparation: the iteration works on magnitudes and
    // the sign is re-applied on the final step.
    // ------------------------------------------------------------------
    always_comb begin
        w_is_div   = bus.func[2];
        w_a_signed = w_is_div ? ~bus.func[0]
                              : ((bus.func[1:0] == 2'b01) || (bus.func[1:0] == 2'b10));
        w_b_signed = w_is_div ? ~bus.func[0] : (bus.func[1:0] == 2'b01);
        w_a_neg    = w_a_signed & bus.SrcA[XLEN-1];
        w_b_neg    = w_b_signed & bus.SrcB[XLEN-1];
        w_mag_a    = w_a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
        w_mag_b    = w_b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
        w_div_zero = (bus.SrcB == '0);
        w_div_ovf  = ~bus.func[0] & (bus.SrcA == c_min) & (bus.SrcB == c_ones);
        w_special  = bus.func[4] & w_is_div & (w_div_zero | w_div_ovf);
        if (w_div_zero) begin
            w_special_res = bus.func[1] ? bus.SrcA : c_ones;
        end else begin
            w_special_res = bus.func[1] ? '0 : bus.SrcA;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step. Multiply: {r_hi,r_lo} is the product register with
    // the multiplier shifting out of r_lo. Divide: r_hi is the partial
    // remainder, r_lo shifts the dividend out and the quotient in.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_opb});
        if (r_op[2]) begin
            w_hi_nxt = w_ge ? XLEN'(w_shift - {1'b0, r_opb}) : w_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    always_comb begin
        w_prod     = {w_hi_nxt, w_lo_nxt};
        w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
        case (r_op)
            3'b000:  w_iter_res = w_prod_fix[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  w_iter_res = w_prod_fix[2*XLEN-1:XLEN];
            3'b100:  w_iter_res = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
            3'b101:  w_iter_res = w_lo_nxt;
            3'b110:  w_iter_res = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
            default: w_iter_res = w_hi_nxt;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_op      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= bus.func[2:0];
                        r_cnt <= '0;
                        if (!bus.func[4]) begin
                            r_alu_out <= w_base_res;
                        end else if (w_special) begin
                            r_alu_out <= w_special_res;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= w_is_div ? w_mag_a : w_mag_b;
                            r_opb   <= w_is_div ? w_mag_b : w_mag_a;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_is_div & w_a_neg;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_alu_out <= w_iter_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = w_valid;
    assign bus.ALUout  = r_alu_out;

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_md
// Purpose  : Scoreboard bench for alu_md at XLEN=32.
// Revision : 1.0
// ============================================================================
module tb_alu_md;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    alu_md_if #(.XLEN(XLEN)) bus ();

    alu_md #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] f);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (!f[4]) begin
            case (f[3:0])
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0001: return a << b[4:0];
                4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'b0011: return (a < b) ? 32'd1 : 32'd0;
                4'b0100: return a ^ b;
                4'b0101: return a >> b[4:0];
                4'b1101: return $unsigned($signed(a) >>> b[4:0]);
                4'b0110: return a | b;
                4'b0111: return a & b;
                4'b1110: return b;
                default: return 32'd0;
            endcase
        end
        case (f[2:0])
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] f);
        if (!f[4]) return 1;
        if (f[2] && b == 0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                        input string name);
        logic [31:0] want;
        int          want_lat;
        int          lat;
        bit          busy_ok;
        exp_q.push_back(model(a, b, f));
        lat_q.push_back(model_lat(a, b, f));
        @(negedge clk);
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_o before accept got %b want 1", name, bus.ready_o);
        end
        bus.valid_i = 1'b1;
        bus.SrcA    = a;
        bus.SrcB    = b;
        bus.func    = f;
        bus.ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.SrcA    = $urandom;
        bus.SrcB    = $urandom;
        bus.func    = 5'($urandom);
        lat     = 1;
        busy_ok = 1'b1;
        while (bus.valid_o !== 1'b1 && lat < 100) begin
            if (bus.ready_o !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        want     = exp_q.pop_front();
        want_lat = lat_q.pop_front();
        checks++;
        if (bus.ALUout !== want) begin
            errors++;
            $display("FAIL %s result got %h want %h", name, bus.ALUout, want);
        end
        checks++;
        if (lat != want_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, want_lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s ready_o while busy got 1 want 0", name);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.ALUout !== want) begin
            errors++;
            $display("FAIL %s retire valid_o=%b ready_o=%b ALUout=%h want 0/1/%h",
                     name, bus.valid_o, bus.ready_o, bus.ALUout, want);
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.ALUout !== 32'd0) begin
            errors++;
            $display("FAIL reset valid_o=%b ready_o=%b ALUout=%h want 0/1/0",
                     bus.valid_o, bus.ready_o, bus.ALUout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_base();
        send(32'd5,          32'd7,          5'b00000, "add");
        send(32'h8000_0000,  32'd4,          5'b01101, "sra");
        send(32'd1,          32'hFFFF_FFFF,  5'b00011, "sltu");
        send(32'd1,          32'hFFFF_FFFF,  5'b00010, "slt");
        send(32'hFFFF_FFFF,  32'd2,          5'b00000, "add_wrap");
        send(32'd3,          32'd5,          5'b01000, "sub_wrap");
        send(32'h0000_00F1,  32'd36,         5'b00001, "sll_mask");
        send(32'h8000_0000,  32'd4,          5'b00101, "srl");
        send(32'hF0F0_1234,  32'h0FF0_4321,  5'b00100, "xor");
        send(32'hF0F0_1234,  32'h0FF0_4321,  5'b00110, "or");
        send(32'hF0F0_1234,  32'h0FF0_4321,  5'b00111, "and");
        send(32'h1111_1111,  32'hCAFE_F00D,  5'b01110, "passb");
        send(32'h1234_5678,  32'h9ABC_DEF0,  5'b01010, "undef");
    endtask

    task automatic test_muldiv();
        send(32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'b10011, "mulhu");
        send(32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'b10001, "mulh");
        send(32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'b10000, "mul");
        send(32'hFFFF_FFF9,  32'd3,          5'b10010, "mulhsu");
        send(32'hFFFF_FFF9,  32'd2,          5'b10100, "div_neg");
        send(32'hFFFF_FFF9,  32'd2,          5'b10110, "rem_neg");
        send(32'd1000,       32'd7,          5'b11101, "divu_f3");
        send(32'hFFFF_FFFF,  32'd10,         5'b10111, "remu");
    endtask

    task automatic test_div_special();
        send(32'd7,          32'd0,          5'b10100, "div_by0");
        send(32'd7,          32'd0,          5'b10111, "remu_by0");
        send(32'h8000_0000,  32'hFFFF_FFFF,  5'b10100, "div_ovf");
        send(32'h8000_0000,  32'hFFFF_FFFF,  5'b10110, "rem_ovf");
        send(32'h8000_0000,  32'hFFFF_FFFF,  5'b10101, "divu_noovf");
    endtask

    task automatic test_hold();
        int waited;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.SrcA    = 32'd3;
        bus.SrcB    = 32'd4;
        bus.func    = 5'b00000;
        bus.ready_i = 1'b0;
        exp_q.push_back(model(32'd3, 32'd4, 5'b00000));
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        waited = 0;
        while (bus.valid_o !== 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.valid_i = i[0];
            bus.SrcA    = 32'(i) * 32'd17;
            bus.SrcB    = 32'd9;
            @(posedge clk);
            #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.ALUout !== exp_q[0]) begin
                errors++;
                $display("FAIL hold cycle %0d valid_o=%b ALUout=%h want 1/%h",
                         i, bus.valid_o, bus.ALUout, exp_q[0]);
            end
        end
        void'(exp_q.pop_front());
        // Release and request in the same cycle: only the release takes effect.
        @(negedge clk);
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.SrcA    = 32'd100;
        bus.SrcB    = 32'd1;
        bus.func    = 5'b00000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle ready_o=%b valid_o=%b want 1/0", bus.ready_o, bus.valid_o);
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.ALUout !== 32'd101) begin
            errors++;
            $display("FAIL next_accept valid_o=%b ALUout=%h want 1/00000065",
                     bus.valid_o, bus.ALUout);
        end
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
    endtask

    task automatic test_reset_midbusy();
        bit busy_ok;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.SrcA    = 32'd1000;
        bus.SrcB    = 32'd3;
        bus.func    = 5'b10101;
        bus.ready_i = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        busy_ok = 1'b1;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0) busy_ok = 1'b0;
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL divu_busy ready_o/valid_o not 0 while busy");
        end
        @(negedge clk);
        rst         = 1'b1;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        bus.func    = 5'b00000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ALUout !== 32'd0 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midbusy_reset valid_o=%b ALUout=%h ready_o=%b want 0/0/1",
                     bus.valid_o, bus.ALUout, bus.ready_o);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        send(32'd20, 32'd22, 5'b00000, "add_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  f;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if (i % 4 == 0) b = b & 32'h0000_001F;
            f = 5'($urandom);
            send(a, b, f, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.SrcA    = '0;
        bus.SrcB    = '0;
        bus.func    = '0;
        test_reset();
        test_base();
        test_muldiv();
        test_div_special();
        test_hold();
        test_reset_midbusy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, 32, operand/result width; SHALL be a power of 2, 8 to 64.
REQ-002 Port clk  input  1  rising-edge clock; the only clock.
REQ-003 Port rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 Port valid_i  input  1  operation request qualifier.
REQ-005 Port ready_o  output  1  block can accept a request this cycle.
REQ-006 Port SrcA  input  XLEN  operand A.
REQ-007 Port SrcB  input  XLEN  operand B.
REQ-008 Port func  input  5  operation select; func[4]=0 base op, func[4]=1 mul/div op.
REQ-009 Port ALUout  output  XLEN  registered result.
REQ-010 Port valid_o  output  1  ALUout holds a result.
REQ-011 Port ready_i  input  1  consumer accepts the result.

Function
REQ-012 Request SHALL be accepted on a rising edge with valid_i=1 and ready_o=1; SrcA, SrcB, func SHALL be captured then; later input changes SHALL NOT affect the result.
REQ-013 FSM states IDLE, BUSY, DONE; ready_o SHALL be 1 only in IDLE.
REQ-014 IDLE: accept of base op or mul/div special case -> DONE; accept of other mul/div -> BUSY; no accept -> stay.
REQ-015 BUSY SHALL last exactly XLEN cycles (one iteration per cycle), then -> DONE.
REQ-016 DONE: valid_o=1; ready_i=1 -> IDLE; ready_i=0 -> stay, with ALUout and valid_o held stable.
REQ-017 Latency: accept at edge N; base op or special case -> valid_o=1 after edge N+1; iterative op -> valid_o=1 after edge N+XLEN+1.
REQ-018 Base ops (func[4]=0, func[3:0]): 0000 A+B; 1000 A-B; 0001 A<<B[S-1:0]; 0010 signed A<B ?1:0; 0011 unsigned A<B ?1:0; 0100 A^B; 0101 logical A>>B[S-1:0]; 1101 arithmetic A>>>B[S-1:0]; 0110 A|B; 0111 A&B; 1110 B; all other codes 0; S=log2(XLEN).
REQ-019 Add/sub SHALL wrap modulo 2^XLEN; no carry/overflow output.
REQ-020 Mul/div ops (func[4]=1, func[2:0]; func[3] ignored): 000 MUL low XLEN bits; 001 MULH signed x signed high; 010 MULHSU signed A x unsigned B high; 011 MULHU unsigned high; 100 DIV signed; 101 DIVU; 110 REM signed; 111 REMU.
REQ-021 Multiply SHALL be iterative shift-add over a 2*XLEN-bit product, sign handled by operand correction or magnitude-plus-negate; result SHALL equal exact mathematical product bits.
REQ-022 Divide SHALL be iterative restoring or non-restoring; signed quotient truncates toward zero; remainder sign equals dividend sign.
REQ-023 Special case divide-by-zero (B=0): DIV/DIVU result all-ones; REM/REMU result A; latency 1 (no BUSY).
REQ-024 Special case signed overflow (DIV/REM, A=most-negative, B=all-ones): DIV result A; REM result 0; latency 1.
REQ-025 valid_o SHALL be 0 in IDLE and BUSY; ALUout SHALL hold the last result outside DONE until overwritten.
REQ-026 valid_i while ready_o=0 SHALL be ignored, request not queued.
REQ-027 Same-cycle ready_i=1 in DONE and valid_i=1 SHALL NOT accept (ready_o=0 in DONE); accept possible the following cycle.

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, ALUout=0, valid_o=0, all iteration registers 0, in any state including mid-BUSY; ready_o=1 from the following cycle.
REQ-029 rst SHALL take priority over valid_i and ready_i in the same cycle.

Verification (XLEN=32)
REQ-030 ADD A=5 B=7 ready_i=1 -> ALUout=0x0000000C, valid_o=1 one cycle after accept; SRA A=0x80000000 B=4 -> 0xF8000000; SLTU A=1 B=0xFFFFFFFF -> 1; SLT same operands -> 0.
REQ-031 MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0; MUL same -> 0x00000001; each valid_o exactly 33 cycles after accept, ready_o=0 throughout.
REQ-032 DIV A=7 B=0 -> 0xFFFFFFFF, REMU A=7 B=0 -> 7, DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000, REM same -> 0; all at latency 1; DIV A=-7 B=2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF at latency 33.
REQ-033 ready_i=0 for 10 cycles in DONE -> ALUout and valid_o=1 stable; valid_i pulses ignored; ready_i=1 -> IDLE next cycle.
REQ-034 rst=1 at cycle 10 of DIVU -> next cycle IDLE, valid_o=0, ALUout=0; fresh ADD then completes normally.
